// File: rtl/mp_icache_ctrl_sequencer_if.sv
// Command and cache-control bus of the multi-cache icache control sequencer.
// The master modport is the sequencer view; the slave modport is the
// register-file / cache side view.
interface mp_icache_ctrl_sequencer_if #(
    parameter int NB_CORES      = 4,
    parameter int NB_CACHES     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int PF_SIZE_WIDTH = 8
);
    logic                                 cmd_valid_i;
    logic                                 cmd_ready_o;
    logic [2:0]                           cmd_op_i;
    logic [NB_CACHES-1:0]                 cmd_mask_i;
    logic [ADDR_WIDTH-1:0]                cmd_addr_i;
    logic [PF_SIZE_WIDTH-1:0]             cmd_size_i;
    logic                                 resp_valid_o;
    logic                                 resp_err_o;
    logic                                 busy_o;
    logic [NB_CACHES-1:0]                 bypass_req_o;
    logic [NB_CACHES*(NB_CORES+1)-1:0]    bypass_ack_i;
    logic [NB_CACHES-1:0]                 flush_req_o;
    logic [NB_CACHES-1:0]                 flush_ack_i;
    logic [NB_CACHES-1:0]                 sel_flush_req_o;
    logic [NB_CACHES-1:0]                 sel_flush_ack_i;
    logic [ADDR_WIDTH-1:0]                sel_flush_addr_o;
    logic [NB_CACHES-1:0]                 pf_req_o;
    logic [NB_CACHES-1:0]                 pf_ack_i;
    logic [NB_CACHES-1:0]                 pf_done_i;
    logic [ADDR_WIDTH-1:0]                pf_addr_o;
    logic [PF_SIZE_WIDTH-1:0]             pf_size_o;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_mask_i, cmd_addr_i, cmd_size_i,
        input  bypass_ack_i, flush_ack_i, sel_flush_ack_i, pf_ack_i, pf_done_i,
        output cmd_ready_o, resp_valid_o, resp_err_o, busy_o,
        output bypass_req_o, flush_req_o, sel_flush_req_o, sel_flush_addr_o,
        output pf_req_o, pf_addr_o, pf_size_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_mask_i, cmd_addr_i, cmd_size_i,
        output bypass_ack_i, flush_ack_i, sel_flush_ack_i, pf_ack_i, pf_done_i,
        input  cmd_ready_o, resp_valid_o, resp_err_o, busy_o,
        input  bypass_req_o, flush_req_o, sel_flush_req_o, sel_flush_addr_o,
        input  pf_req_o, pf_addr_o, pf_size_o
    );
endinterface

// File: rtl/mp_icache_ctrl_sequencer.sv
// Multi-cache icache control sequencer: accepts one command at a time,
// broadcasts it to a mask of caches, collects acks, enforces a watchdog and
// returns one done/error pulse per command. All outputs are registered.
module mp_icache_ctrl_sequencer #(
    parameter int NB_CORES       = 4,
    parameter int NB_CACHES      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int PF_SIZE_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic clk_i,
    input logic rst_ni,
    mp_icache_ctrl_sequencer_if.master bus
);
    localparam int ACK_W = NB_CORES + 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] OP_BYP_ON    = 3'd0;
    localparam logic [2:0] OP_BYP_OFF   = 3'd1;
    localparam logic [2:0] OP_FLUSH     = 3'd2;
    localparam logic [2:0] OP_SEL_FLUSH = 3'd3;
    localparam logic [2:0] OP_PREFETCH  = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        BYP_WAIT,
        FLUSH_WAIT,
        SFLUSH_WAIT,
        PF_ACK_WAIT,
        PF_DONE_WAIT,
        RESP
    } state_t;

    state_t                   state_q, state_d;
    logic [NB_CACHES-1:0]     mask_q, mask_d;
    logic [NB_CACHES-1:0]     pending_q, pending_d;
    logic [NB_CACHES-1:0]     done_q, done_d;
    logic [WD_W-1:0]          wdog_q, wdog_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     resp_valid_q, resp_valid_d;
    logic                     resp_err_q, resp_err_d;
    logic                     busy_q, busy_d;
    logic [NB_CACHES-1:0]     bypass_q, bypass_d;
    logic [NB_CACHES-1:0]     flush_q, flush_d;
    logic [NB_CACHES-1:0]     sflush_q, sflush_d;
    logic [NB_CACHES-1:0]     pf_q, pf_d;
    logic [ADDR_WIDTH-1:0]    sf_addr_q, sf_addr_d;
    logic [ADDR_WIDTH-1:0]    pf_addr_q, pf_addr_d;
    logic [PF_SIZE_WIDTH-1:0] pf_size_q, pf_size_d;

    logic [NB_CACHES-1:0]     byp_match;
    logic [NB_CACHES-1:0]     pend_left;
    logic [NB_CACHES-1:0]     done_next;
    logic                     wdog_hit;
    logic                     go_resp;
    logic                     go_err;

    // A cache has settled its bypass change once every core ack equals the requested level.
    always_comb begin
        byp_match = '0;
        for (int c = 0; c < NB_CACHES; c++) begin
            byp_match[c] = (bus.bypass_ack_i[c*ACK_W +: ACK_W] == {ACK_W{bypass_q[c]}});
        end
    end

    // Next-state and next registered-output logic for the command sequencer.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        pending_d    = pending_q;
        done_d       = done_q;
        wdog_d       = wdog_q;
        bypass_d     = bypass_q;
        flush_d      = '0;
        sflush_d     = '0;
        pf_d         = '0;
        sf_addr_d    = sf_addr_q;
        pf_addr_d    = pf_addr_q;
        pf_size_d    = pf_size_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        pend_left    = '0;
        done_next    = done_q;
        go_resp      = 1'b0;
        go_err       = 1'b0;
        wdog_hit     = (TIMEOUT_CYCLES != 0) && (wdog_q == WD_LAST);

        if (state_q != IDLE && state_q != RESP) begin
            wdog_d = wdog_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    mask_d    = bus.cmd_mask_i;
                    pending_d = bus.cmd_mask_i;
                    done_d    = '0;
                    wdog_d    = '0;
                    if (bus.cmd_op_i > OP_PREFETCH) begin
                        go_resp = 1'b1;
                        go_err  = 1'b1;
                    end else if (bus.cmd_mask_i == '0) begin
                        go_resp = 1'b1;
                    end else begin
                        unique case (bus.cmd_op_i)
                            OP_BYP_ON: begin
                                bypass_d = bypass_q | bus.cmd_mask_i;
                                state_d  = BYP_WAIT;
                            end
                            OP_BYP_OFF: begin
                                bypass_d = bypass_q & ~bus.cmd_mask_i;
                                state_d  = BYP_WAIT;
                            end
                            OP_FLUSH: begin
                                flush_d = bus.cmd_mask_i;
                                state_d = FLUSH_WAIT;
                            end
                            OP_SEL_FLUSH: begin
                                sflush_d  = bus.cmd_mask_i;
                                sf_addr_d = bus.cmd_addr_i;
                                state_d   = SFLUSH_WAIT;
                            end
                            default: begin
                                pf_d      = bus.cmd_mask_i;
                                pf_addr_d = bus.cmd_addr_i;
                                pf_size_d = bus.cmd_size_i;
                                state_d   = PF_ACK_WAIT;
                            end
                        endcase
                    end
                end
            end
            BYP_WAIT: begin
                if (&(byp_match | ~mask_q)) begin
                    go_resp = 1'b1;
                end else if (wdog_hit) begin
                    go_resp = 1'b1;
                    go_err  = 1'b1;
                end
            end
            FLUSH_WAIT: begin
                pend_left = pending_q & ~bus.flush_ack_i;
                if (pend_left == '0) begin
                    go_resp = 1'b1;
                end else if (wdog_hit) begin
                    go_resp = 1'b1;
                    go_err  = 1'b1;
                end else begin
                    pending_d = pend_left;
                    flush_d   = pend_left;
                end
            end
            SFLUSH_WAIT: begin
                pend_left = pending_q & ~bus.sel_flush_ack_i;
                if (pend_left == '0) begin
                    go_resp = 1'b1;
                end else if (wdog_hit) begin
                    go_resp = 1'b1;
                    go_err  = 1'b1;
                end else begin
                    pending_d = pend_left;
                    sflush_d  = pend_left;
                end
            end
            PF_ACK_WAIT: begin
                done_next = done_q | (bus.pf_done_i & mask_q);
                done_d    = done_next;
                pend_left = pending_q & ~bus.pf_ack_i;
                if (pend_left == '0) begin
                    if (done_next == mask_q) begin
                        go_resp = 1'b1;
                    end else begin
                        pending_d = '0;
                        state_d   = PF_DONE_WAIT;
                    end
                end else if (wdog_hit) begin
                    go_resp = 1'b1;
                    go_err  = 1'b1;
                end else begin
                    pending_d = pend_left;
                    pf_d      = pend_left;
                end
            end
            PF_DONE_WAIT: begin
                done_next = done_q | (bus.pf_done_i & mask_q);
                done_d    = done_next;
                if (done_next == mask_q) begin
                    go_resp = 1'b1;
                end else if (wdog_hit) begin
                    go_resp = 1'b1;
                    go_err  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_resp) begin
            state_d      = RESP;
            pending_d    = '0;
            flush_d      = '0;
            sflush_d     = '0;
            pf_d         = '0;
            resp_valid_d = 1'b1;
            resp_err_d   = go_err;
        end

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset returns everything, bypass levels included, to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            pending_q    <= '0;
            done_q       <= '0;
            wdog_q       <= '0;
            cmd_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            bypass_q     <= '0;
            flush_q      <= '0;
            sflush_q     <= '0;
            pf_q         <= '0;
            sf_addr_q    <= '0;
            pf_addr_q    <= '0;
            pf_size_q    <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            done_q       <= done_d;
            wdog_q       <= wdog_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
            bypass_q     <= bypass_d;
            flush_q      <= flush_d;
            sflush_q     <= sflush_d;
            pf_q         <= pf_d;
            sf_addr_q    <= sf_addr_d;
            pf_addr_q    <= pf_addr_d;
            pf_size_q    <= pf_size_d;
        end
    end

    assign bus.cmd_ready_o      = cmd_ready_q;
    assign bus.resp_valid_o     = resp_valid_q;
    assign bus.resp_err_o       = resp_err_q;
    assign bus.busy_o           = busy_q;
    assign bus.bypass_req_o     = bypass_q;
    assign bus.flush_req_o      = flush_q;
    assign bus.sel_flush_req_o  = sflush_q;
    assign bus.sel_flush_addr_o = sf_addr_q;
    assign bus.pf_req_o         = pf_q;
    assign bus.pf_addr_o        = pf_addr_q;
    assign bus.pf_size_o        = pf_size_q;
endmodule

// File: tb/tb_mp_icache_ctrl_sequencer.sv
// Directed bench for mp_icache_ctrl_sequencer: a vector table of whole
// commands plus hand-written sequences for the multi-cycle corner cases.
module tb_mp_icache_ctrl_sequencer;
    localparam int NB_CORES       = 4;
    localparam int NB_CACHES      = 2;
    localparam int ADDR_WIDTH     = 32;
    localparam int PF_SIZE_WIDTH  = 8;
    localparam int TIMEOUT_CYCLES = 16;

    localparam logic [2:0] OP_BYP_ON    = 3'd0;
    localparam logic [2:0] OP_BYP_OFF   = 3'd1;
    localparam logic [2:0] OP_FLUSH     = 3'd2;
    localparam logic [2:0] OP_SEL_FLUSH = 3'd3;
    localparam logic [2:0] OP_PREFETCH  = 3'd4;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  mask;
        logic [31:0] addr;
        logic [7:0]  size;
        int          ack0;
        int          ack1;
        int          done0;
        int          done1;
        int          exp_lat;
        logic        exp_err;
        logic [1:0]  exp_byp;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   total = 0;
    int   bad   = 0;

    always #5 clk_i = ~clk_i;

    mp_icache_ctrl_sequencer_if #(
        .NB_CORES(NB_CORES), .NB_CACHES(NB_CACHES),
        .ADDR_WIDTH(ADDR_WIDTH), .PF_SIZE_WIDTH(PF_SIZE_WIDTH)
    ) bus ();

    mp_icache_ctrl_sequencer #(
        .NB_CORES(NB_CORES), .NB_CACHES(NB_CACHES), .ADDR_WIDTH(ADDR_WIDTH),
        .PF_SIZE_WIDTH(PF_SIZE_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic waitReady();
        int k = 0;
        while (bus.cmd_ready_o !== 1'b1 && k < 64) begin
            tick();
            k++;
        end
        if (bus.cmd_ready_o !== 1'b1) checkOutput("wait_ready", 64'(bus.cmd_ready_o), 64'd1);
    endtask

    task automatic startCmd(input logic [2:0] op, input logic [1:0] mask, input logic [31:0] addr, input logic [7:0] size);
        waitReady();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_mask_i  = mask;
        bus.cmd_addr_i  = addr;
        bus.cmd_size_i  = size;
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic clearAcks();
        bus.flush_ack_i     = '0;
        bus.sel_flush_ack_i = '0;
        bus.pf_ack_i        = '0;
        bus.pf_done_i       = '0;
    endtask

    task automatic driveAcks(input vec_t v, input int n);
        logic [1:0] a;
        logic [1:0] d;
        a[0] = (v.ack0 == n);
        a[1] = (v.ack1 == n);
        d[0] = (v.done0 == n);
        d[1] = (v.done1 == n);
        bus.flush_ack_i     = (v.op == OP_FLUSH) ? a : 2'b00;
        bus.sel_flush_ack_i = (v.op == OP_SEL_FLUSH) ? a : 2'b00;
        bus.pf_ack_i        = (v.op == OP_PREFETCH) ? a : 2'b00;
        bus.pf_done_i       = (v.op == OP_PREFETCH) ? d : 2'b00;
        if (v.op == OP_BYP_ON || v.op == OP_BYP_OFF) begin
            if (a[0]) bus.bypass_ack_i[4:0] = {5{v.op == OP_BYP_ON}};
            if (a[1]) bus.bypass_ack_i[9:5] = {5{v.op == OP_BYP_ON}};
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        int   first = -1;
        int   cnt = 0;
        logic err_seen = 1'b0;
        logic any_req = 1'b0;
        startCmd(v.op, v.mask, v.addr, v.size);
        for (int n = 1; n <= v.exp_lat + 1; n++) begin
            driveAcks(v, n);
            if ((bus.flush_req_o | bus.sel_flush_req_o | bus.pf_req_o) != 2'b00) any_req = 1'b1;
            if (bus.resp_valid_o === 1'b1) begin
                cnt++;
                if (first < 0) begin
                    first    = n;
                    err_seen = bus.resp_err_o;
                end
            end
            if (n == v.exp_lat)
                checkOutput({name, "_req_idle"}, 64'({bus.flush_req_o, bus.sel_flush_req_o, bus.pf_req_o}), 64'd0);
            if (n == v.exp_lat + 1) checkOutput({name, "_ready"}, 64'(bus.cmd_ready_o), 64'd1);
            tick();
        end
        clearAcks();
        checkOutput({name, "_lat"}, 64'(first), 64'(v.exp_lat));
        checkOutput({name, "_resp_cnt"}, 64'(cnt), 64'd1);
        checkOutput({name, "_err"}, 64'(err_seen), 64'(v.exp_err));
        checkOutput({name, "_bypass"}, 64'(bus.bypass_req_o), 64'(v.exp_byp));
        if (v.exp_lat == 1) checkOutput({name, "_no_req"}, 64'(any_req), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        vec_t  vecs[12];
        string names[12];
        vec_t  v;
        int    first;
        int    stable_bad;
        logic  flush_seen;
        logic [1:0] exp_fr[1:8];

        vecs[0]  = '{OP_FLUSH,     2'b11, 32'h0,        8'h0, 3, 6, 0,  0, 7,  1'b0, 2'b00};
        vecs[1]  = '{OP_BYP_ON,    2'b10, 32'h0,        8'h0, 0, 2, 0,  0, 3,  1'b0, 2'b10};
        vecs[2]  = '{OP_BYP_OFF,   2'b10, 32'h0,        8'h0, 0, 1, 0,  0, 2,  1'b0, 2'b00};
        vecs[3]  = '{OP_SEL_FLUSH, 2'b01, 32'h1C000100, 8'h0, 1, 0, 0,  0, 2,  1'b0, 2'b00};
        vecs[4]  = '{OP_PREFETCH,  2'b11, 32'h00002000, 8'h8, 2, 4, 12, 4, 13, 1'b0, 2'b00};
        vecs[5]  = '{3'd6,         2'b11, 32'h0,        8'h0, 0, 0, 0,  0, 1,  1'b1, 2'b00};
        vecs[6]  = '{3'd5,         2'b00, 32'h0,        8'h0, 0, 0, 0,  0, 1,  1'b1, 2'b00};
        vecs[7]  = '{OP_FLUSH,     2'b00, 32'h0,        8'h0, 0, 0, 0,  0, 1,  1'b0, 2'b00};
        vecs[8]  = '{OP_FLUSH,     2'b01, 32'h0,        8'h0, 0, 0, 0,  0, 17, 1'b1, 2'b00};
        vecs[9]  = '{OP_FLUSH,     2'b01, 32'h0,        8'h0, 5, 2, 0,  0, 6,  1'b0, 2'b00};
        vecs[10] = '{OP_PREFETCH,  2'b01, 32'h00003000, 8'h4, 3, 0, 2,  0, 4,  1'b0, 2'b00};
        vecs[11] = '{OP_PREFETCH,  2'b10, 32'h00004000, 8'h4, 0, 2, 0,  0, 17, 1'b1, 2'b00};
        names = '{"flush_both", "byp_on_c1", "byp_off_c1", "sflush_c0", "pf_both",
                  "illegal_op6", "illegal_op5_mask0", "flush_mask0", "flush_timeout",
                  "flush_after_to", "pf_done_first", "pf_done_timeout"};
        exp_fr = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};

        rst_ni              = 1'b0;
        bus.cmd_valid_i     = 1'b0;
        bus.cmd_op_i        = '0;
        bus.cmd_mask_i      = '0;
        bus.cmd_addr_i      = '0;
        bus.cmd_size_i      = '0;
        bus.bypass_ack_i    = '0;
        clearAcks();

        repeat (3) tick();
        checkOutput("rst_ready", 64'(bus.cmd_ready_o), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy_o), 64'd0);
        checkOutput("rst_reqs", 64'({bus.bypass_req_o, bus.flush_req_o, bus.sel_flush_req_o, bus.pf_req_o}), 64'd0);
        checkOutput("rst_resp", 64'({bus.resp_valid_o, bus.resp_err_o}), 64'd0);
        rst_ni = 1'b1;
        tick();
        checkOutput("post_rst_ready", 64'(bus.cmd_ready_o), 64'd1);
        checkOutput("post_rst_busy", 64'(bus.busy_o), 64'd0);

        // Full flush with acks at T+3 and T+6, request levels checked cycle by cycle.
        startCmd(OP_FLUSH, 2'b11, 32'h0, 8'h0);
        first = -1;
        for (int n = 1; n <= 8; n++) begin
            bus.flush_ack_i = {n == 6, n == 3};
            checkOutput($sformatf("fl_req_c%0d", n), 64'(bus.flush_req_o), 64'(exp_fr[n]));
            if (bus.resp_valid_o === 1'b1 && first < 0) first = n;
            if (n == 7) checkOutput("fl_err", 64'(bus.resp_err_o), 64'd0);
            if (n == 8) checkOutput("fl_ready", 64'(bus.cmd_ready_o), 64'd1);
            tick();
        end
        clearAcks();
        checkOutput("fl_resp_cycle", 64'(first), 64'd7);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], names[i]);
        end

        // Selective flush: address stable while requested, mid-operation command ignored.
        startCmd(OP_SEL_FLUSH, 2'b11, 32'h1C008040, 8'h0);
        first = -1;
        stable_bad = 0;
        flush_seen = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            bus.sel_flush_ack_i = (n == 5) ? 2'b11 : 2'b00;
            bus.cmd_valid_i     = (n == 2);
            bus.cmd_op_i        = OP_FLUSH;
            bus.cmd_mask_i      = 2'b11;
            if (n == 1) checkOutput("sf_addr", 64'(bus.sel_flush_addr_o), 64'h1C008040);
            if (n == 2) checkOutput("sf_busy_not_ready", 64'(bus.cmd_ready_o), 64'd0);
            if (n == 6) checkOutput("sf_req_dropped", 64'(bus.sel_flush_req_o), 64'd0);
            if (bus.sel_flush_req_o != 2'b00 && bus.sel_flush_addr_o != 32'h1C008040) stable_bad++;
            if (bus.flush_req_o != 2'b00) flush_seen = 1'b1;
            if (bus.resp_valid_o === 1'b1 && first < 0) first = n;
            tick();
        end
        bus.cmd_valid_i = 1'b0;
        clearAcks();
        checkOutput("sf_resp_cycle", 64'(first), 64'd6);
        checkOutput("sf_addr_stable", 64'(stable_bad), 64'd0);
        checkOutput("sf_ignored_cmd", 64'(flush_seen), 64'd0);
        checkOutput("sf_idle_after", 64'({bus.cmd_ready_o, bus.busy_o}), 64'b10);

        // Bypass on with a partial ack vector first, then bypass off.
        startCmd(OP_BYP_ON, 2'b01, 32'h0, 8'h0);
        first = -1;
        for (int n = 1; n <= 7; n++) begin
            bus.bypass_ack_i[4:0] = (n <= 4) ? 5'b01111 : 5'b11111;
            if (bus.resp_valid_o === 1'b1 && first < 0) first = n;
            tick();
        end
        checkOutput("byp_partial_resp", 64'(first), 64'd6);
        checkOutput("byp_on_level", 64'(bus.bypass_req_o), 64'b01);
        startCmd(OP_BYP_OFF, 2'b01, 32'h0, 8'h0);
        first = -1;
        for (int n = 1; n <= 5; n++) begin
            if (n == 3) bus.bypass_ack_i[4:0] = 5'b00000;
            if (bus.resp_valid_o === 1'b1 && first < 0) first = n;
            tick();
        end
        checkOutput("byp_off_resp", 64'(first), 64'd4);
        checkOutput("byp_off_level", 64'(bus.bypass_req_o), 64'b00);

        // Asynchronous reset while a prefetch waits for acks.
        v = '{OP_BYP_ON, 2'b11, 32'h0, 8'h0, 1, 1, 0, 0, 2, 1'b0, 2'b11};
        applyStimulus(v, "byp_all");
        startCmd(OP_PREFETCH, 2'b11, 32'h1C000000, 8'h8);
        tick();
        tick();
        checkOutput("pf_req_before_rst", 64'(bus.pf_req_o), 64'b11);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_pf_req", 64'(bus.pf_req_o), 64'd0);
        checkOutput("arst_bypass", 64'(bus.bypass_req_o), 64'd0);
        checkOutput("arst_status", 64'({bus.busy_o, bus.cmd_ready_o, bus.resp_valid_o}), 64'd0);
        checkOutput("arst_pf_addr_size", 64'({bus.pf_addr_o, bus.pf_size_o}), 64'd0);
        bus.bypass_ack_i = '0;
        tick();
        rst_ni = 1'b1;
        tick();
        checkOutput("rearst_ready", 64'(bus.cmd_ready_o), 64'd1);
        v = '{3'd7, 2'b01, 32'h0, 8'h0, 0, 0, 0, 0, 1, 1'b1, 2'b00};
        applyStimulus(v, "post_rst_illegal");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
